ssp_tx_fifo_param: RTL and testbench

- Parametrised successor to the SSP transmit FIFO. Buffers APB-written transmit words ahead of the serial shifter.
- Configurable data width and depth, a programmable watermark interrupt, an occupancy count, full/empty flags, and defined simultaneous push/pop behaviour.
- Sits between the APB slave decode (psel/pwrite/pwdata) and the SSP transmit shift logic, which pops entries with t_en.

---
 rtl/ssp_tx_fifo_param.sv | 142 ++++++++++++++
 tb/tb_ssp_tx_fifo_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ssp_tx_fifo_param.sv
// ssp_tx_fifo_param: parametrised SSP transmit FIFO.
// Buffers APB-written words (psel & pwrite) ahead of the serial shifter,
// which pops with t_en. First-word fall-through head, occupancy count,
// full/valid flags and a level watermark interrupt (count <= TX_WM).
// All outputs come straight from registers; no input reaches an output
// combinationally.
// Optional feature: define TX_FIFO_OVERRUN_FLAG_EN to add ovr_clr/tx_ovr,
// a sticky flag recording pushes dropped because the FIFO was full.
module ssp_tx_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int TX_WM  = DEPTH / 2
) (
  input  logic              pclk,
  input  logic              clear,
  input  logic              psel,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              t_en,
  output logic [DATA_W-1:0] txdata,
  output logic              tx_valid,
  output logic              tx_full,
  output logic [PTR_W:0]    tx_count,
  output logic              ssptxintr
`ifdef TX_FIFO_OVERRUN_FLAG_EN
  ,
  input  logic              ovr_clr,
  output logic              tx_ovr
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WM_C    = CNT_W'(TX_WM);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              push_req_s;
  logic              pop_req_s;
  logic              push_acc_s;
  logic              pop_acc_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [DATA_W-1:0] head_nxt_s;

  // Request decode and acceptance; a pop frees a slot for a same-cycle push.
  always_comb begin
    push_req_s = psel & pwrite;
    pop_req_s  = t_en;
    pop_acc_s  = pop_req_s & (count_r != {CNT_W{1'b0}});
    push_acc_s = push_req_s & ((count_r != DEPTH_C) | pop_acc_s);
  end

  // Next pointers, next count and the word that will sit at the head.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = {DATA_W{1'b0}};

    if (pop_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    if (push_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (push_acc_s && !pop_acc_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_acc_s && !push_acc_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end

    // The head slot is being written this cycle only when the new head is
    // the write slot (FIFO draining to empty or already empty).
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {DATA_W{1'b0}};
    end else if (push_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = pwdata;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge pclk) begin
    if (push_acc_s && !clear) begin
      mem_r[wr_ptr_r] <= pwdata;
    end
  end

  // Pointer, count and registered output flags; clear beats push and pop.
  always_ff @(posedge pclk) begin
    if (clear) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      txdata    <= {DATA_W{1'b0}};
      tx_valid  <= 1'b0;
      tx_full   <= 1'b0;
      ssptxintr <= 1'b1;
    end else begin
      rd_ptr_r  <= rd_ptr_nxt_s;
      wr_ptr_r  <= wr_ptr_nxt_s;
      count_r   <= count_nxt_s;
      txdata    <= head_nxt_s;
      tx_valid  <= (count_nxt_s != {CNT_W{1'b0}});
      tx_full   <= (count_nxt_s == DEPTH_C);
      ssptxintr <= (count_nxt_s <= WM_C);
    end
  end

  assign tx_count = count_r;

`ifdef TX_FIFO_OVERRUN_FLAG_EN
  // Sticky overrun flag: a dropped push sets it and wins over ovr_clr.
  always_ff @(posedge pclk) begin
    if (clear) begin
      tx_ovr <= 1'b0;
    end else if (push_req_s && !push_acc_s) begin
      tx_ovr <= 1'b1;
    end else if (ovr_clr) begin
      tx_ovr <= 1'b0;
    end else begin
      tx_ovr <= tx_ovr;
    end
  end
`endif

endmodule

// File: tb/tb_ssp_tx_fifo_param.sv
// Self-checking bench for ssp_tx_fifo_param (DEPTH=4, TX_WM=2, DATA_W=8).
// A queue holds the words the bench expects the FIFO to contain; pushes the
// bench expects to be accepted go on the back, pops compare txdata with the
// front. Outputs are sampled on the falling edge, inputs change there too.
module tb_ssp_tx_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int WM    = 2;

  logic          pclk = 1'b0;
  logic          clear;
  logic          psel;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          t_en;
  logic [DW-1:0] txdata;
  logic          tx_valid;
  logic          tx_full;
  logic [2:0]    tx_count;
  logic          ssptxintr;
`ifdef TX_FIFO_OVERRUN_FLAG_EN
  logic          ovr_clr;
  logic          tx_ovr;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  logic          ovr_m;

  ssp_tx_fifo_param #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .TX_WM  (WM)
  ) dut (
    .pclk      (pclk),
    .clear     (clear),
    .psel      (psel),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .t_en      (t_en),
    .txdata    (txdata),
    .tx_valid  (tx_valid),
    .tx_full   (tx_full),
    .tx_count  (tx_count),
    .ssptxintr (ssptxintr)
`ifdef TX_FIFO_OVERRUN_FLAG_EN
    ,
    .ovr_clr   (ovr_clr),
    .tx_ovr    (tx_ovr)
`endif
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check_eq("tx_count", 32'(tx_count), 32'(n));
    check_eq("tx_valid", 32'(tx_valid), 32'(n != 0));
    check_eq("tx_full", 32'(tx_full), 32'(n == DEPTH));
    check_eq("ssptxintr", 32'(ssptxintr), 32'(n <= WM));
    if (n > 0) check_eq("txdata_head", 32'(txdata), 32'(exp_q[0]));
    else       check_eq("txdata_zero", 32'(txdata), 32'h0);
`ifdef TX_FIFO_OVERRUN_FLAG_EN
    check_eq("tx_ovr", 32'(tx_ovr), 32'(ovr_m));
`endif
  endtask

  task automatic idle_inputs();
    clear  = 1'b0;
    psel   = 1'b0;
    pwrite = 1'b0;
    pwdata = 8'h00;
    t_en   = 1'b0;
`ifdef TX_FIFO_OVERRUN_FLAG_EN
    ovr_clr = 1'b0;
`endif
  endtask

  // One clock cycle: check current state, drive a request, update the model.
  task automatic step(input logic sel, input logic wr, input logic [DW-1:0] d,
                      input logic pop, input logic oclr);
    logic          pop_acc;
    logic          push_acc;
    logic [DW-1:0] popped;
    check_outputs();
    psel   = sel;
    pwrite = wr;
    pwdata = d;
    t_en   = pop;
`ifdef TX_FIFO_OVERRUN_FLAG_EN
    ovr_clr = oclr;
`endif
    pop_acc  = pop && (exp_q.size() > 0);
    push_acc = sel && wr && ((exp_q.size() < DEPTH) || pop_acc);
    if (pop_acc) begin
      popped = exp_q.pop_front();
      check_eq("pop_data", 32'(txdata), 32'(popped));
    end
    if (push_acc) exp_q.push_back(d);
    if (sel && wr && !push_acc) ovr_m = 1'b1;
    else if (oclr)              ovr_m = 1'b0;
    @(negedge pclk);
    idle_inputs();
  endtask

  // Clear cycle with a simultaneous push request that must be dropped.
  task automatic do_clear();
    check_outputs();
    clear  = 1'b1;
    psel   = 1'b1;
    pwrite = 1'b1;
    pwdata = 8'hEE;
    t_en   = 1'b1;
    exp_q.delete();
    ovr_m = 1'b0;
    @(negedge pclk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    clear = 1'b1;
    ovr_m = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    clear = 1'b0;

    // Fill 00..03, watermark falls at count 3, full after the fourth.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    // Read-only access (pwrite=0) must not push.
    step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    // Push while full without pop is dropped.
    step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef TX_FIFO_OVERRUN_FLAG_EN
    // Dropped push coinciding with ovr_clr: set wins.
    step(1'b1, 1'b1, 8'h05, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
`endif
    // Drain 00..03, then pop on empty is ignored.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Refill, then push AA with a pop while full.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Push with pop on empty: pop ignored, 55 appears next cycle.
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap: alternating push and pop, ten words.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Clear with count=3 and a push request in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    do_clear();
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Overrun then explicit clear of the flag.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
